// File: rtl/dmi_abscmd_seq_if.sv
// rtl/dmi_abscmd_seq_if.sv - DPort request/response bundle between the abstract-command sequencer and ic_dport
interface dmi_abscmd_seq_if #(
    parameter int DPORT_REQ_TOTAL = 5,
    parameter int RISCV_ARCH      = 64
);
    logic                       o_dport_req_valid;
    logic [DPORT_REQ_TOTAL-1:0] o_dport_req_type;
    logic [RISCV_ARCH-1:0]      o_dport_addr;
    logic [RISCV_ARCH-1:0]      o_dport_wdata;
    logic [2:0]                 o_dport_size;
    logic                       i_dport_req_ready;
    logic                       o_dport_resp_ready;
    logic                       i_dport_resp_valid;
    logic                       i_dport_resp_error;
    logic [RISCV_ARCH-1:0]      i_dport_rdata;

    modport master (
        output o_dport_req_valid, o_dport_req_type, o_dport_addr, o_dport_wdata, o_dport_size,
        output o_dport_resp_ready,
        input  i_dport_req_ready, i_dport_resp_valid, i_dport_resp_error, i_dport_rdata
    );

    modport slave (
        input  o_dport_req_valid, o_dport_req_type, o_dport_addr, o_dport_wdata, o_dport_size,
        input  o_dport_resp_ready,
        output i_dport_req_ready, i_dport_resp_valid, i_dport_resp_error, i_dport_rdata
    );
endinterface

// File: rtl/dmi_abscmd_seq.sv
// rtl/dmi_abscmd_seq.sv - Access Register abstract command to DPort request sequencer
module dmi_abscmd_seq #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        i_clk,
    input  logic        i_nrst,
    input  logic        i_cmd_valid,
    input  logic [7:0]  i_cmdtype,
    input  logic [23:0] i_control,
    input  logic [63:0] i_wdata,
    input  logic        i_halted,
    input  logic [2:0]  i_cmderr_clr,
    output logic        o_busy,
    output logic [2:0]  o_cmderr,
    output logic        o_rdata_valid,
    output logic [63:0] o_rdata,
    dmi_abscmd_seq_if.master dport
);
    localparam int REQ_TOTAL = 5;
    localparam int ARCH      = 64;
    localparam int TW        = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [REQ_TOTAL-1:0] REQ_WRITE    = 5'b00001;
    localparam logic [REQ_TOTAL-1:0] REQ_REGACC   = 5'b00010;
    localparam logic [REQ_TOTAL-1:0] REQ_PROGEXEC = 5'b10000;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_REG_REQ   = 3'd1;
    localparam logic [2:0] ST_REG_RESP  = 3'd2;
    localparam logic [2:0] ST_EXEC_REQ  = 3'd3;
    localparam logic [2:0] ST_EXEC_RESP = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [2:0]    cmderr_q, cmderr_d;
    logic [15:0]   regno_q, regno_d;
    logic [2:0]    size_q, size_d;
    logic          postexec_q, postexec_d;
    logic          write_q, write_d;
    logic [63:0]   wdata_q, wdata_d;
    logic [63:0]   rdata_q, rdata_d;
    logic          rdata_valid_q, rdata_valid_d;
    logic [TW-1:0] timer_q, timer_d;

    logic                 req_valid;
    logic [REQ_TOTAL-1:0] req_type;
    logic [ARCH-1:0]      req_addr;
    logic [ARCH-1:0]      req_wdata;
    logic [2:0]           req_size;
    logic                 resp_ready;
    logic                 timeout;
    logic [2:0]           cmd_size;
    logic                 unused_ctl;

    assign cmd_size   = i_control[22:20];
    assign timeout    = (timer_q == TMO_LAST);
    assign unused_ctl = ^{i_control[23], i_control[19]};

    always_comb begin
        state_d       = state_q;
        cmderr_d      = cmderr_q & ~i_cmderr_clr;
        regno_d       = regno_q;
        size_d        = size_q;
        postexec_d    = postexec_q;
        write_d       = write_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        timer_d       = '0;
        req_valid     = 1'b0;
        req_type      = '0;
        req_addr      = '0;
        req_wdata     = '0;
        req_size      = 3'd0;
        resp_ready    = 1'b0;

        // A command arriving mid-sequence is dropped; an FSM error below overrides this
        if (i_cmd_valid && (state_q != ST_IDLE) && (cmderr_q == 3'd0)) begin
            cmderr_d = 3'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (i_cmd_valid && (cmderr_q == 3'd0)) begin
                    regno_d    = i_control[15:0];
                    size_d     = cmd_size;
                    postexec_d = i_control[18];
                    write_d    = i_control[16];
                    wdata_d    = (cmd_size == 3'd2) ? {32'h0, i_wdata[31:0]} : i_wdata;
                    if (i_cmdtype != 8'd0) begin
                        cmderr_d = 3'd2;
                    end else if (i_control[17] && (cmd_size != 3'd2) && (cmd_size != 3'd3)) begin
                        cmderr_d = 3'd2;
                    end else if (!i_halted) begin
                        cmderr_d = 3'd4;
                    end else if (i_control[17]) begin
                        state_d = ST_REG_REQ;
                    end else if (i_control[18]) begin
                        state_d = ST_EXEC_REQ;
                    end
                end
            end
            ST_REG_REQ: begin
                req_valid = !timeout;
                req_type  = write_q ? (REQ_REGACC | REQ_WRITE) : REQ_REGACC;
                req_addr  = ARCH'(regno_q);
                req_wdata = wdata_q;
                req_size  = size_q;
                if (timeout) begin
                    cmderr_d = 3'd7;
                    state_d  = ST_IDLE;
                end else if (dport.i_dport_req_ready) begin
                    state_d = ST_REG_RESP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_REG_RESP: begin
                resp_ready = 1'b1;
                if (dport.i_dport_resp_valid) begin
                    if (dport.i_dport_resp_error) begin
                        cmderr_d = 3'd3;
                        state_d  = ST_IDLE;
                    end else begin
                        if (!write_q) begin
                            rdata_d = (size_q == 3'd2) ? {32'h0, dport.i_dport_rdata[31:0]}
                                                       : dport.i_dport_rdata;
                            rdata_valid_d = 1'b1;
                        end
                        state_d = postexec_q ? ST_EXEC_REQ : ST_IDLE;
                    end
                end
            end
            ST_EXEC_REQ: begin
                req_valid = !timeout;
                req_type  = REQ_PROGEXEC;
                if (timeout) begin
                    cmderr_d = 3'd7;
                    state_d  = ST_IDLE;
                end else if (dport.i_dport_req_ready) begin
                    state_d = ST_EXEC_RESP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_EXEC_RESP: begin
                resp_ready = 1'b1;
                if (dport.i_dport_resp_valid) begin
                    if (dport.i_dport_resp_error) begin
                        cmderr_d = 3'd3;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q       <= ST_IDLE;
            cmderr_q      <= 3'd0;
            regno_q       <= 16'd0;
            size_q        <= 3'd0;
            postexec_q    <= 1'b0;
            write_q       <= 1'b0;
            wdata_q       <= 64'd0;
            rdata_q       <= 64'd0;
            rdata_valid_q <= 1'b0;
            timer_q       <= '0;
        end else begin
            state_q       <= state_d;
            cmderr_q      <= cmderr_d;
            regno_q       <= regno_d;
            size_q        <= size_d;
            postexec_q    <= postexec_d;
            write_q       <= write_d;
            wdata_q       <= wdata_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            timer_q       <= timer_d;
        end
    end

    assign o_busy        = (state_q != ST_IDLE);
    assign o_cmderr      = cmderr_q;
    assign o_rdata       = rdata_q;
    assign o_rdata_valid = rdata_valid_q;

    assign dport.o_dport_req_valid  = req_valid;
    assign dport.o_dport_req_type   = req_type;
    assign dport.o_dport_addr       = req_addr;
    assign dport.o_dport_wdata      = req_wdata;
    assign dport.o_dport_size       = req_size;
    assign dport.o_dport_resp_ready = resp_ready;
endmodule

// File: tb/tb_dmi_abscmd_seq.sv
// tb/tb_dmi_abscmd_seq.sv - directed self-checking bench for dmi_abscmd_seq
module tb_dmi_abscmd_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [7:0]  cmdtype = 8'd0;
    logic [23:0] control = 24'd0;
    logic [63:0] wdata = 64'd0;
    logic        halted = 1'b0;
    logic [2:0]  clr = 3'd0;
    logic        busy;
    logic [2:0]  cmderr;
    logic        rvalid;
    logic [63:0] rdata;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    dmi_abscmd_seq_if dp ();

    dmi_abscmd_seq #(.TIMEOUT_CYCLES(8)) dut (
        .i_clk         (clk),
        .i_nrst        (rst_n),
        .i_cmd_valid   (cmd_valid),
        .i_cmdtype     (cmdtype),
        .i_control     (control),
        .i_wdata       (wdata),
        .i_halted      (halted),
        .i_cmderr_clr  (clr),
        .o_busy        (busy),
        .o_cmderr      (cmderr),
        .o_rdata_valid (rvalid),
        .o_rdata       (rdata),
        .dport         (dp)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic issue(input logic [7:0] t, input logic [23:0] c, input logic [63:0] w);
        cmdtype   = t;
        control   = c;
        wdata     = w;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        cmdtype   = 8'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        dp.i_dport_req_ready  = 1'b0;
        dp.i_dport_resp_valid = 1'b0;
        dp.i_dport_resp_error = 1'b0;
        dp.i_dport_rdata      = 64'd0;
        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_cmderr", cmderr, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_req_valid", dp.o_dport_req_valid, 0);
        chk("rst_resp_ready", dp.o_dport_resp_ready, 0);
        rst_n = 1'b1;
        step();

        // Read x5, aarsize 2
        halted = 1'b1;
        dp.i_dport_req_ready = 1'b1;
        issue(8'h00, 24'h220005, 64'h0);
        chk("rd_busy1", busy, 1);
        chk("rd_req_valid", dp.o_dport_req_valid, 1);
        chk("rd_req_type", dp.o_dport_req_type, 5'b00010);
        chk("rd_addr", dp.o_dport_addr, 64'd5);
        chk("rd_size", dp.o_dport_size, 2);
        step();
        chk("rd_resp_ready", dp.o_dport_resp_ready, 1);
        chk("rd_req_dropped", dp.o_dport_req_valid, 0);
        step();
        chk("rd_busy3", busy, 1);
        dp.i_dport_resp_valid = 1'b1;
        dp.i_dport_rdata = 64'hDEAD_BEEF_1234_5678;
        step();
        dp.i_dport_resp_valid = 1'b0;
        chk("rd_busy_fall", busy, 0);
        chk("rd_rvalid", rvalid, 1);
        chk("rd_rdata", rdata, 64'h0000_0000_1234_5678);
        chk("rd_cmderr", cmderr, 0);
        step();
        chk("rd_rvalid_pulse", rvalid, 0);

        // Write x1, aarsize 3, postexec
        issue(8'h00, 24'h370001, 64'hA5A5_A5A5_A5A5_A5A5);
        chk("wr_req_type", dp.o_dport_req_type, 5'b00011);
        chk("wr_addr", dp.o_dport_addr, 64'd1);
        chk("wr_size", dp.o_dport_size, 3);
        chk("wr_wdata", dp.o_dport_wdata, 64'hA5A5_A5A5_A5A5_A5A5);
        step();
        dp.i_dport_resp_valid = 1'b1;
        dp.i_dport_rdata = 64'h1111;
        step();
        dp.i_dport_resp_valid = 1'b0;
        chk("wr_no_rvalid", rvalid, 0);
        chk("ex_req_valid", dp.o_dport_req_valid, 1);
        chk("ex_req_type", dp.o_dport_req_type, 5'b10000);
        chk("ex_addr", dp.o_dport_addr, 0);
        chk("ex_wdata", dp.o_dport_wdata, 0);
        chk("ex_size", dp.o_dport_size, 0);
        step();
        chk("ex_resp_ready", dp.o_dport_resp_ready, 1);
        chk("ex_busy", busy, 1);
        dp.i_dport_resp_valid = 1'b1;
        step();
        dp.i_dport_resp_valid = 1'b0;
        chk("ex_busy_fall", busy, 0);
        chk("ex_no_rvalid", rvalid, 0);
        chk("ex_rdata_kept", rdata, 64'h0000_0000_1234_5678);
        chk("ex_cmderr", cmderr, 0);

        // Not halted, then ignored command, then W1C clear
        halted = 1'b0;
        issue(8'h00, 24'h220005, 64'h0);
        chk("nh_busy", busy, 0);
        chk("nh_req_valid", dp.o_dport_req_valid, 0);
        chk("nh_cmderr", cmderr, 4);
        halted = 1'b1;
        issue(8'h00, 24'h220005, 64'h0);
        chk("ign_busy", busy, 0);
        chk("ign_cmderr", cmderr, 4);
        clr = 3'd7;
        step();
        clr = 3'd0;
        chk("clr_cmderr", cmderr, 0);

        // Unsupported cmdtype and aarsize
        issue(8'h01, 24'h220005, 64'h0);
        chk("ct_cmderr", cmderr, 2);
        chk("ct_busy", busy, 0);
        clr = 3'd2;
        step();
        clr = 3'd0;
        chk("ct_clr", cmderr, 0);
        issue(8'h00, 24'h420005, 64'h0);
        chk("sz_cmderr", cmderr, 2);
        clr = 3'd7;
        step();
        clr = 3'd0;

        // No transfer, no postexec: silent no-op even with bad aarsize
        issue(8'h00, 24'h100000, 64'h0);
        chk("nop_busy", busy, 0);
        chk("nop_cmderr", cmderr, 0);

        // Postexec only
        issue(8'h00, 24'h040000, 64'h0);
        chk("pe_req_valid", dp.o_dport_req_valid, 1);
        chk("pe_req_type", dp.o_dport_req_type, 5'b10000);
        step();
        dp.i_dport_resp_valid = 1'b1;
        step();
        dp.i_dport_resp_valid = 1'b0;
        chk("pe_busy", busy, 0);
        chk("pe_cmderr", cmderr, 0);

        // Second command while busy
        issue(8'h00, 24'h220005, 64'h0);
        step();
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        chk("bz_cmderr", cmderr, 1);
        chk("bz_busy", busy, 1);
        chk("bz_resp_ready", dp.o_dport_resp_ready, 1);
        dp.i_dport_resp_valid = 1'b1;
        dp.i_dport_rdata = 64'hFFFF_FFFF_8765_4321;
        step();
        dp.i_dport_resp_valid = 1'b0;
        chk("bz_busy_fall", busy, 0);
        chk("bz_rvalid", rvalid, 1);
        chk("bz_rdata", rdata, 64'h0000_0000_8765_4321);
        chk("bz_cmderr_kept", cmderr, 1);
        clr = 3'd7;
        step();
        clr = 3'd0;

        // Timeout with req_ready held low; ready rises only in the drop cycle
        dp.i_dport_req_ready = 1'b0;
        issue(8'h00, 24'h320005, 64'h0);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("to_req_valid_%0d", i), dp.o_dport_req_valid, 1);
            step();
        end
        chk("to_req_dropped", dp.o_dport_req_valid, 0);
        chk("to_busy_last", busy, 1);
        dp.i_dport_req_ready = 1'b1;
        step();
        chk("to_busy", busy, 0);
        chk("to_cmderr", cmderr, 7);
        chk("to_resp_ready", dp.o_dport_resp_ready, 0);
        clr = 3'd7;
        step();
        clr = 3'd0;

        // Response error on read with postexec; new error beats simultaneous clear
        issue(8'h00, 24'h260005, 64'h0);
        step();
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        chk("er_cmderr1", cmderr, 1);
        dp.i_dport_resp_valid = 1'b1;
        dp.i_dport_resp_error = 1'b1;
        clr = 3'd7;
        step();
        dp.i_dport_resp_valid = 1'b0;
        dp.i_dport_resp_error = 1'b0;
        clr = 3'd0;
        chk("er_cmderr3", cmderr, 3);
        chk("er_busy", busy, 0);
        chk("er_rvalid", rvalid, 0);
        chk("er_no_exec", dp.o_dport_req_valid, 0);
        chk("er_rdata_kept", rdata, 64'h0000_0000_8765_4321);
        clr = 3'd1;
        step();
        chk("er_clr_bit0", cmderr, 2);
        clr = 3'd2;
        step();
        clr = 3'd0;
        chk("er_clr_bit1", cmderr, 0);

        // Async reset while waiting for a response
        issue(8'h00, 24'h220005, 64'h0);
        step();
        chk("ar_resp_ready", dp.o_dport_resp_ready, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_busy", busy, 0);
        chk("ar_resp_ready0", dp.o_dport_resp_ready, 0);
        chk("ar_req_valid", dp.o_dport_req_valid, 0);
        chk("ar_rdata", rdata, 0);
        chk("ar_rvalid", rvalid, 0);
        step();
        rst_n = 1'b1;
        dp.i_dport_resp_valid = 1'b1;
        dp.i_dport_rdata = 64'h5555;
        step();
        dp.i_dport_resp_valid = 1'b0;
        chk("ar_stale_rvalid", rvalid, 0);
        chk("ar_stale_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
